// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
//   alu_op_e    : 4-bit opcode encoding on i_alu_fun
//   alu_state_e : control FSM states (IDLE accepts work, BUSY runs a divide)
//   CMP_*_CODE  : result codes returned by the compare opcodes
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_XOR  = 4'h8,
    OP_XNOR = 4'h9,
    OP_CMPE = 4'hA,
    OP_CMPG = 4'hB,
    OP_CMPL = 4'hC,
    OP_SLL  = 4'hD,
    OP_SLR  = 4'hE,
    OP_ROT  = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  localparam logic [1:0] CMP_EQ_CODE = 2'd1;
  localparam logic [1:0] CMP_GT_CODE = 2'd2;
  localparam logic [1:0] CMP_LT_CODE = 2'd3;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first quotient bit is produced on the start edge itself, so a divide
// launched at edge N finishes its W-th iteration at edge N+W-1 and 'done'
// is high for the one cycle that follows. Quotient/remainder then hold until
// the next start.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               load operands and perform the first iteration
//   dividend, divisor   W-bit unsigned operands (divisor must be non-zero)
//   done                1-cycle pulse, quotient/remainder are final
//   quotient, remainder W-bit results
module alu_div_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  div_r;
  logic [CW-1:0] cnt;
  logic          busy;

  logic [W-1:0]  src_rem, src_quo, src_div;
  logic [W:0]    shifted, trial;
  logic [W-1:0]  nxt_rem, nxt_quo;

  // One restoring step; on the start edge it works on the fresh operands.
  always_comb begin
    src_rem = start ? '0 : remainder;
    src_quo = start ? dividend : quotient;
    src_div = start ? divisor : div_r;
    shifted = {src_rem, src_quo[W-1]};
    trial   = shifted - {1'b0, src_div};
    if (!trial[W]) begin
      nxt_rem = trial[W-1:0];
      nxt_quo = {src_quo[W-2:0], 1'b1};
    end else begin
      nxt_rem = shifted[W-1:0];
      nxt_quo = {src_quo[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      div_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        div_r     <= divisor;
        quotient  <= nxt_quo;
        remainder <= nxt_rem;
        cnt       <= CW'(W - 1);
        busy      <= 1'b1;
      end else if (busy) begin
        quotient  <= nxt_quo;
        remainder <= nxt_rem;
        cnt       <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake and zero/error flags.
// Operands are captured at accept (stage p0); single-cycle ops register their
// result one edge later. A divide with a non-zero divisor runs on alu_div_seq
// while the FSM sits in BUSY with o_ready low; its result is registered one
// edge after the FSM returns to IDLE (accept at N -> o_valid at N+W+1).
// Optional feature macro ALU_VAR_SHIFT_EN: variable shift amount from
// i_operan_b and opcode 4'hF becomes a rotate (i_operan_b[$clog2(W)] = 1 selects
// rotate-right, otherwise rotate-left). Without it, shifts are by one and 4'hF
// is an illegal opcode.
// Ports:
//   i_clk, i_arst_n           clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready         request handshake, accept = i_valid & o_ready
//   i_alu_fun                 opcode (alu_op_e)
//   i_operan_a, i_operan_b    W-bit unsigned operands
//   o_alu_res                 2W-bit result, held between completions
//   o_valid                   1-cycle completion pulse
//   o_zero, o_err             result-is-zero, divide-by-zero/illegal-opcode
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int FUN = 4
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [FUN-1:0] i_alu_fun,
  input  logic [W-1:0]   i_operan_a,
  input  logic [W-1:0]   i_operan_b,
  output logic [2*W-1:0] o_alu_res,
  output logic           o_valid,
  output logic           o_zero,
  output logic           o_err
);

  localparam int RW = 2 * W;

  function automatic logic [RW-1:0] zext(input logic [W-1:0] v);
    return {{W{1'b0}}, v};
  endfunction

  alu_state_e    state;
  alu_op_e       op_in;
  logic          accept, div_start;

  alu_op_e       op_p0;
  logic [W-1:0]  a_p0, b_p0;
  logic          vld_p0;

  logic          div_done;
  logic [W-1:0]  div_quo, div_rem;
  logic [RW-1:0] div_res;
  logic          div_vld_p1;

  logic [RW-1:0] a_x, b_x, res_p0;
  logic          err_p0;
  logic [W-1:0]  shl_p0, shr_p0;
`ifdef ALU_VAR_SHIFT_EN
  localparam int SW = $clog2(W);
  logic [SW-1:0] amt_p0;
  logic [W-1:0]  rol_p0, ror_p0;
`endif

  assign accept    = i_valid & o_ready;
  assign op_in     = alu_op_e'(i_alu_fun);
  // A zero divisor never enters BUSY; it completes through the 1-cycle path.
  assign div_start = accept && (op_in == OP_DIV) && (i_operan_b != '0);
  assign div_res   = {div_rem, div_quo};

  alu_div_seq #(.W(W)) u_div (
    .clk       (i_clk),
    .rst_n     (i_arst_n),
    .start     (div_start),
    .dividend  (i_operan_a),
    .divisor   (i_operan_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // ---- stage p0: operand capture at accept ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_p0 <= op_in;
      a_p0  <= i_operan_a;
      b_p0  <= i_operan_b;
    end
  end

  always_comb begin
    a_x    = zext(a_p0);
    b_x    = zext(b_p0);
    res_p0 = '0;
    err_p0 = 1'b0;
`ifdef ALU_VAR_SHIFT_EN
    amt_p0 = b_p0[SW-1:0];
    shl_p0 = a_p0 << amt_p0;
    shr_p0 = a_p0 >> amt_p0;
    // Amount 0 shifts the wrap-around term out entirely, leaving A unchanged.
    rol_p0 = shl_p0 | (a_p0 >> (W - int'(amt_p0)));
    ror_p0 = shr_p0 | (a_p0 << (W - int'(amt_p0)));
`else
    shl_p0 = a_p0 << 1;
    shr_p0 = a_p0 >> 1;
`endif
    case (op_p0)
      OP_ADD:  res_p0 = a_x + b_x;
      OP_SUB:  res_p0 = a_x - b_x;
      OP_MUL:  res_p0 = a_x * b_x;
      OP_DIV:  begin
        res_p0 = '1;
        err_p0 = 1'b1;
      end
      OP_AND:  res_p0 = zext(a_p0 & b_p0);
      OP_OR:   res_p0 = zext(a_p0 | b_p0);
      OP_NAND: res_p0 = zext(~(a_p0 & b_p0));
      OP_NOR:  res_p0 = zext(~(a_p0 | b_p0));
      OP_XOR:  res_p0 = zext(a_p0 ^ b_p0);
      OP_XNOR: res_p0 = zext(~(a_p0 ^ b_p0));
      OP_CMPE: res_p0 = (a_p0 == b_p0) ? RW'(CMP_EQ_CODE) : '0;
      OP_CMPG: res_p0 = (a_p0 >  b_p0) ? RW'(CMP_GT_CODE) : '0;
      OP_CMPL: res_p0 = (a_p0 <  b_p0) ? RW'(CMP_LT_CODE) : '0;
      OP_SLL:  res_p0 = zext(shl_p0);
      OP_SLR:  res_p0 = zext(shr_p0);
      OP_ROT:  begin
`ifdef ALU_VAR_SHIFT_EN
        res_p0 = zext(b_p0[SW] ? ror_p0 : rol_p0);
`else
        err_p0 = 1'b1;
`endif
      end
      default: err_p0 = 1'b1;
    endcase
  end

  // ---- stage p1: FSM, completion and output/flag registers ----
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      vld_p0     <= 1'b0;
      div_vld_p1 <= 1'b0;
      o_valid    <= 1'b0;
      o_alu_res  <= '0;
      o_zero     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      vld_p0     <= 1'b0;
      div_vld_p1 <= 1'b0;
      o_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            state   <= BUSY;
            o_ready <= 1'b0;
          end else if (accept) begin
            vld_p0 <= 1'b1;
          end
        end
        BUSY: begin
          if (div_done) begin
            state      <= IDLE;
            o_ready    <= 1'b1;
            div_vld_p1 <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
      // The two completion sources are never active in the same cycle.
      if (vld_p0) begin
        o_alu_res <= res_p0;
        o_zero    <= (res_p0 == '0);
        o_err     <= err_p0;
        o_valid   <= 1'b1;
      end else if (div_vld_p1) begin
        o_alu_res <= div_res;
        o_zero    <= (div_res == '0);
        o_err     <= 1'b0;
        o_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int RW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic [3:0]    fun   = 4'h0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          ready, ovalid, zero, err;
  logic [RW-1:0] res;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.W(W), .FUN(4)) dut (
    .i_clk      (clk),
    .i_arst_n   (rst_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_alu_fun  (fun),
    .i_operan_a (a),
    .i_operan_b (b),
    .o_alu_res  (res),
    .o_valid    (ovalid),
    .o_zero     (zero),
    .o_err      (err)
  );

  typedef struct {
    alu_op_e     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input alu_op_e op, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] r, input logic z, input logic e);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = r; v.zero = z; v.err = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int busy_low, early_valid, seen_valid, ready_drop;

    add_vec(OP_ADD,  8'd200, 8'd100, 16'h012C, 1'b0, 1'b0);
    add_vec(OP_ADD,  8'hFF,  8'hFF,  16'h01FE, 1'b0, 1'b0);
    add_vec(OP_SUB,  8'd5,   8'd7,   16'hFFFE, 1'b0, 1'b0);
    add_vec(OP_SUB,  8'd7,   8'd5,   16'h0002, 1'b0, 1'b0);
    add_vec(OP_SUB,  8'd5,   8'd5,   16'h0000, 1'b1, 1'b0);
    add_vec(OP_MUL,  8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0);
    add_vec(OP_DIV,  8'd9,   8'd0,   16'hFFFF, 1'b0, 1'b1);
    add_vec(OP_AND,  8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0);
    add_vec(OP_OR,   8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0);
    add_vec(OP_NAND, 8'hF0,  8'h3C,  16'h00CF, 1'b0, 1'b0);
    add_vec(OP_NOR,  8'hF0,  8'h0F,  16'h0000, 1'b1, 1'b0);
    add_vec(OP_XOR,  8'hAA,  8'hAA,  16'h0000, 1'b1, 1'b0);
    add_vec(OP_XNOR, 8'hA5,  8'hA4,  16'h00FE, 1'b0, 1'b0);
    add_vec(OP_CMPE, 8'd7,   8'd7,   16'h0001, 1'b0, 1'b0);
    add_vec(OP_CMPE, 8'd7,   8'd8,   16'h0000, 1'b1, 1'b0);
    add_vec(OP_CMPG, 8'd9,   8'd4,   16'h0002, 1'b0, 1'b0);
    add_vec(OP_CMPG, 8'd4,   8'd9,   16'h0000, 1'b1, 1'b0);
    add_vec(OP_CMPL, 8'd3,   8'd4,   16'h0003, 1'b0, 1'b0);
    add_vec(OP_CMPL, 8'd4,   8'd3,   16'h0000, 1'b1, 1'b0);
`ifdef ALU_VAR_SHIFT_EN
    add_vec(OP_SLL,  8'h81,  8'h03,  16'h0008, 1'b0, 1'b0);
    add_vec(OP_SLR,  8'h81,  8'h03,  16'h0010, 1'b0, 1'b0);
    add_vec(OP_SLL,  8'h81,  8'h00,  16'h0081, 1'b0, 1'b0);
    add_vec(OP_ROT,  8'h81,  8'h03,  16'h000C, 1'b0, 1'b0);
    add_vec(OP_ROT,  8'h81,  8'h0B,  16'h0030, 1'b0, 1'b0);
`else
    add_vec(OP_SLL,  8'h81,  8'h03,  16'h0002, 1'b0, 1'b0);
    add_vec(OP_SLR,  8'h81,  8'h03,  16'h0040, 1'b0, 1'b0);
    add_vec(OP_SLL,  8'h80,  8'h00,  16'h0000, 1'b1, 1'b0);
    add_vec(OP_ROT,  8'h81,  8'h03,  16'h0000, 1'b1, 1'b1);
`endif
    add_vec(OP_ADD,  8'd1,   8'd2,   16'h0003, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_valid", ovalid, 1'b0);
    check("rst_res", res, 16'h0000);
    check("rst_zero", zero, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle ops
    foreach (vecs[i]) begin
      @(negedge clk);
      valid = 1'b1; fun = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      valid = 1'b0;
      check($sformatf("v%0d_%s_ready", i, vecs[i].op.name()), ready, 1'b1);
      check($sformatf("v%0d_%s_nopulse", i, vecs[i].op.name()), ovalid, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_%s_valid", i, vecs[i].op.name()), ovalid, 1'b1);
      check($sformatf("v%0d_%s_res", i, vecs[i].op.name()), res, vecs[i].res);
      check($sformatf("v%0d_%s_zero", i, vecs[i].op.name()), zero, vecs[i].zero);
      check($sformatf("v%0d_%s_err", i, vecs[i].op.name()), err, vecs[i].err);
    end

    // Back-to-back ADD then SUB
    @(negedge clk);
    valid = 1'b1; fun = OP_ADD; a = 8'd200; b = 8'd100;
    @(negedge clk);
    fun = OP_SUB; a = 8'd5; b = 8'd7;
    @(negedge clk);
    valid = 1'b0;
    check("b2b_valid1", ovalid, 1'b1);
    check("b2b_res1", res, 16'h012C);
    check("b2b_err1", err, 1'b0);
    @(negedge clk);
    check("b2b_valid2", ovalid, 1'b1);
    check("b2b_res2", res, 16'hFFFE);
    check("b2b_err2", err, 1'b0);
    @(negedge clk);
    check("b2b_valid_drop", ovalid, 1'b0);
    check("b2b_res_hold", res, 16'hFFFE);

    // DIV 200/7 with i_valid held during BUSY
    @(negedge clk);
    valid = 1'b1; fun = OP_DIV; a = 8'd200; b = 8'd7;
    @(negedge clk);
    fun = OP_ADD; a = 8'd1; b = 8'd1;
    busy_low = 0; early_valid = 0;
    for (int k = 0; k < W; k++) begin
      if (ready == 1'b0) busy_low++;
      if (ovalid) early_valid++;
      if (k == W - 1) valid = 1'b0;
      @(negedge clk);
    end
    check("div_ready_low_cycles", busy_low, W);
    check("div_no_early_valid", early_valid, 0);
    check("div_ready_back", ready, 1'b1);
    check("div_valid_not_yet", ovalid, 1'b0);
    @(negedge clk);
    check("div_valid", ovalid, 1'b1);
    check("div_res", res, 16'h041C);
    check("div_err", err, 1'b0);
    check("div_zero", zero, 1'b0);
    @(negedge clk);
    check("div_held_ivalid_ignored", ovalid, 1'b0);
    check("div_res_hold", res, 16'h041C);

    // Reset in the third BUSY cycle aborts the divide
    @(negedge clk);
    valid = 1'b1; fun = OP_DIV; a = 8'd200; b = 8'd7;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_valid", ovalid, 1'b0);
    check("midrst_res", res, 16'h0000);
    check("midrst_zero", zero, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0; ready_drop = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (ovalid) seen_valid++;
      if (!ready) ready_drop++;
    end
    check("midrst_no_valid_after", seen_valid, 0);
    check("midrst_ready_stays", ready_drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
